sd_sector_buffer: RTL and testbench
===================================

SD_SECTOR_BUFFER -- requirements
Module: sd_sector_buffer

Interface
REQ-001 SHALL have parameter SECTOR_BYTES, default 512, meaning the number of bytes per sector transfer.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000, meaning the clk cycles allowed from execute to finished_sector before an error is raised.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port btn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: the host requests a sector operation.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the block accepts a command.
REQ-007 SHALL have port cmd_write, input, 1 bit: 1 means write the buffer to the card; 0 means read the card into the buffer.
REQ-008 SHALL have port cmd_addr, input, 26 bits: the sector address.
REQ-009 SHALL have port host_addr, input, 9 bits: the buffer byte index.
REQ-010 SHALL have port host_we, input, 1 bit: the host buffer write strobe.
REQ-011 SHALL have port host_wdata, input, 8 bits: the host buffer write data.
REQ-012 SHALL have port host_rdata, output, 8 bits: the buffer read data.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle pulse when an operation completes.
REQ-014 SHALL have port error, output, 1 bit: a sticky error flag, cleared by the next accepted command.
REQ-015 SHALL have ports op_code (output, 1), execute (output, 1), sector_address (output, 26) and outgoing_byte (output, 8): these drive the SD card controller.
REQ-016 SHALL have ports incoming_byte (input, 8), finished_byte (input, 1), finished_sector (input, 1) and busy (input, 1): these come from the SD card controller.

Function
REQ-017 SHALL implement an FSM with states IDLE, ISSUE, WAIT_BUSY, XFER and FINISH.
REQ-018 SHALL assert cmd_ready only in IDLE, and only while busy=0.
REQ-019 SHALL accept a command on cmd_valid&cmd_ready, then:
- latch cmd_write to op_code and cmd_addr to sector_address;
- clear idx and error;
- go to ISSUE.
REQ-020 In ISSUE, SHALL drive execute=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-021 In WAIT_BUSY, SHALL go to XFER on busy=1.
REQ-022 In write mode, outgoing_byte SHALL equal mem[idx], registered, valid from the cycle after entry to XFER.
REQ-023 In write mode, each finished_byte pulse SHALL increment idx, and outgoing_byte SHALL update on the following cycle.
REQ-024 In read mode, each finished_byte pulse SHALL write incoming_byte to mem[idx], then increment idx.
REQ-025 finished_byte pulses received while idx==SECTOR_BYTES SHALL be ignored and SHALL set error.
REQ-026 On finished_sector in XFER, SHALL go to FINISH; if idx!=SECTOR_BYTES at that point, error SHALL be set.
REQ-027 finished_byte and finished_sector in the same cycle SHALL both be honoured: the byte is counted first.
REQ-028 In FINISH, SHALL wait for busy=0, pulse done for one cycle and return to IDLE.
REQ-029 The timeout counter SHALL run from ISSUE through XFER; on reaching TIMEOUT_CYCLES it SHALL set error, pulse done and return to IDLE.
REQ-030 Host buffer writes SHALL occur only in IDLE; host_we outside IDLE SHALL be ignored.
REQ-031 host_rdata SHALL equal mem[host_addr] with one-cycle latency in every state.
REQ-032 cmd_valid outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-033 On btn=0, regardless of the current operation, SHALL force:
- state=IDLE, idx=0, timeout counter=0;
- execute=0, op_code=0, sector_address=0, outgoing_byte=0;
- done=0, error=0, host_rdata=0.
REQ-034 Buffer contents SHALL NOT be reset.
REQ-035 A reset mid-operation SHALL leave no pending execute after btn returns to 1.

Structure
REQ-036 State encodings, SECTOR_BYTES and the op_code values (READ=0, WRITE=1) SHALL be placed in a shared package used by this block and sd_card_controller.
REQ-037 The buffer SHALL be a separate sub-module, sector_ram: 512x8 single-clock dual-port RAM with registered read, inferable as block RAM.

Verification
REQ-038 Reset: hold btn=0 for 50 cycles -> all outputs 0, cmd_ready=1 after release.
REQ-039 Read: cmd_write=0, cmd_addr=0x0000123; model returns bytes i&0xFF over 512 finished_byte pulses, then finished_sector -> exactly one execute pulse, sector_address=0x0000123, done once, error=0, host_rdata at 0x1FF reads 0xFF.
REQ-040 Write: host fills the buffer with 0xA5^i, cmd_write=1 -> model captures 512 outgoing_byte values matching 0xA5^i in order, op_code=1, done once.
REQ-041 Short sector: finished_sector after 100 bytes -> done pulses and error=1; the next accepted command clears error.
REQ-042 Timeout: with TIMEOUT_CYCLES=1000, busy never asserts -> error=1 and done at cycle 1000±2 after execute.
REQ-043 Reset mid-XFER at byte 200 -> IDLE next cycle, no further execute, and a new command then completes normally.

Source files
------------

// File: rtl/sd_sector_buffer_pkg.sv
// Shared definitions for the SD sector buffer and the SD card controller:
// FSM encoding, sector size and op_code values.
package sd_sector_buffer_pkg;
  localparam int   SECTOR_BYTES = 512;
  localparam int   RAM_ADDR_W   = 9;
  localparam logic OP_READ      = 1'b0;
  localparam logic OP_WRITE     = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    XFER,
    FINISH
  } buf_state_e;
endpackage

// File: rtl/sd_sector_buffer_ram.sv
// 512x8 true dual-port sector RAM, single clock, registered read on both ports.
// The two write ports are never active in the same cycle in this design.
module sector_ram
  import sd_sector_buffer_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (we_b) mem[addr_b] <= wdata_b;
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end
endmodule

// File: rtl/sd_sector_buffer.sv
// Sector buffer between a host and the SD card controller: holds one sector
// in RAM and sequences a single read or write transfer per accepted command.
module sd_sector_buffer
  import sd_sector_buffer_pkg::*;
#(
  parameter int SECTOR_BYTES   = sd_sector_buffer_pkg::SECTOR_BYTES,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        btn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [25:0] cmd_addr,
  input  logic [8:0]  host_addr,
  input  logic        host_we,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        done,
  output logic        error,
  output logic        op_code,
  output logic        execute,
  output logic [25:0] sector_address,
  output logic [7:0]  outgoing_byte,
  input  logic [7:0]  incoming_byte,
  input  logic        finished_byte,
  input  logic        finished_sector,
  input  logic        busy
);
  localparam int               IDX_W    = $clog2(SECTOR_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(SECTOR_BYTES);
  localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  buf_state_e             state_reg, state_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [31:0]            tmo_reg, tmo_next;
  logic                   op_reg, op_next;
  logic [25:0]            sa_reg, sa_next;
  logic                   error_reg, error_next;
  logic                   done_reg, done_next;
  logic                   active_reg;
  logic                   ram_we_b;
  logic [RAM_ADDR_W-1:0]  ram_addr_b;
  logic [7:0]             ram_q_a, ram_q_b;

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      tmo_reg    <= '0;
      op_reg     <= OP_READ;
      sa_reg     <= '0;
      error_reg  <= 1'b0;
      done_reg   <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      tmo_reg    <= tmo_next;
      op_reg     <= op_next;
      sa_reg     <= sa_next;
      error_reg  <= error_next;
      done_reg   <= done_next;
      active_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tmo_next   = tmo_reg;
    op_next    = op_reg;
    sa_next    = sa_reg;
    error_next = error_reg;
    done_next  = 1'b0;
    ram_we_b   = 1'b0;
    cmd_ready  = (state_reg == IDLE) && !busy && active_reg;
    execute    = (state_reg == ISSUE);
    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_next    = cmd_write;
          sa_next    = cmd_addr;
          idx_next   = '0;
          tmo_next   = '0;
          error_next = 1'b0;
          state_next = ISSUE;
        end
      end
      ISSUE, WAIT_BUSY, XFER: begin
        if (tmo_reg == TMO_LAST) begin
          error_next = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + 32'd1;
          case (state_reg)
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (busy) state_next = XFER;
            default: begin
              // A byte arriving with the sector closing is counted before the length check.
              if (finished_byte) begin
                if (idx_reg == IDX_FULL) begin
                  error_next = 1'b1;
                end else begin
                  idx_next = idx_reg + IDX_W'(1);
                  ram_we_b = (op_reg == OP_READ);
                end
              end
              if (finished_sector) begin
                state_next = FINISH;
                if (idx_next != IDX_FULL) error_next = 1'b1;
              end
            end
          endcase
        end
      end
      FINISH: begin
        if (!busy) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Writes address the current slot; reads look ahead so outgoing_byte follows idx by one cycle.
  assign ram_addr_b = (op_reg == OP_WRITE) ? RAM_ADDR_W'(idx_next) : RAM_ADDR_W'(idx_reg);

  sector_ram u_ram (
    .clk     (clk),
    .we_a    (host_we && (state_reg == IDLE)),
    .addr_a  (host_addr),
    .wdata_a (host_wdata),
    .rdata_a (ram_q_a),
    .we_b    (ram_we_b),
    .addr_b  (ram_addr_b),
    .wdata_b (incoming_byte),
    .rdata_b (ram_q_b)
  );

  // RAM output registers have no reset, so the read data is held at zero until reset releases.
  assign host_rdata     = active_reg ? ram_q_a : 8'h00;
  assign outgoing_byte  = active_reg ? ram_q_b : 8'h00;
  assign op_code        = op_reg;
  assign sector_address = sa_reg;
  assign done           = done_reg;
  assign error          = error_reg;
endmodule

// File: tb/tb_sd_sector_buffer.sv
// Self-checking bench for sd_sector_buffer: host buffer vectors, spec transfers,
// corner sequences and randomized transfers against a byte-array buffer model.
module tb_sd_sector_buffer;
  logic        clk = 1'b0;
  logic        btn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [25:0] cmd_addr = '0;
  logic [8:0]  host_addr = '0;
  logic        host_we = 1'b0;
  logic [7:0]  host_wdata = '0;
  logic [7:0]  incoming_byte = '0;
  logic        finished_byte = 1'b0, finished_sector = 1'b0, busy = 1'b0;
  logic        cmd_ready, done, error, op_code, execute;
  logic [7:0]  host_rdata, outgoing_byte;
  logic [25:0] sector_address;

  logic        to_cmd_valid = 1'b0;
  logic        to_cmd_ready, to_done, to_error, to_op_code, to_execute;
  logic [7:0]  to_host_rdata, to_outgoing_byte;
  logic [25:0] to_sector_address;

  int tests = 0, fails = 0;
  int cyc = 0;
  int exec_cnt = 0, done_cnt = 0, to_exec_cnt = 0;
  int to_exec_cyc = -1, to_done_cyc = -1;
  logic [7:0] model [512];

  typedef struct {
    logic       we;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } host_vec_t;
  host_vec_t vecs [8];

  sd_sector_buffer dut (
    .clk(clk), .btn(btn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .host_addr(host_addr),
    .host_we(host_we), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .done(done), .error(error), .op_code(op_code), .execute(execute),
    .sector_address(sector_address), .outgoing_byte(outgoing_byte),
    .incoming_byte(incoming_byte), .finished_byte(finished_byte),
    .finished_sector(finished_sector), .busy(busy)
  );

  sd_sector_buffer #(.TIMEOUT_CYCLES(1000)) to_dut (
    .clk(clk), .btn(btn), .cmd_valid(to_cmd_valid), .cmd_ready(to_cmd_ready),
    .cmd_write(1'b0), .cmd_addr(26'h0000042), .host_addr(9'h000),
    .host_we(1'b0), .host_wdata(8'h00), .host_rdata(to_host_rdata),
    .done(to_done), .error(to_error), .op_code(to_op_code), .execute(to_execute),
    .sector_address(to_sector_address), .outgoing_byte(to_outgoing_byte),
    .incoming_byte(8'h00), .finished_byte(1'b0),
    .finished_sector(1'b0), .busy(1'b0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (execute) exec_cnt++;
    if (done) done_cnt++;
    if (to_execute) begin
      to_exec_cnt++;
      if (to_exec_cyc < 0) to_exec_cyc = cyc;
    end
    if (to_done && to_done_cyc < 0) to_done_cyc = cyc;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [8:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    tick();
    host_we = 1'b0;
    model[a] = d;
  endtask

  task automatic host_read_check(input string name, input logic [8:0] a);
    host_addr = a;
    tick();
    check(name, 32'(host_rdata), 32'(model[a]));
  endtask

  task automatic issue_cmd(input logic wr, input logic [25:0] a, output int e0);
    int n = 0;
    e0 = exec_cnt;
    cmd_write = wr; cmd_addr = a; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'(~wr);
    cmd_addr = 26'($urandom);
    check("cmd_err_clear", 32'(error), 32'(1'b0));
    check("cmd_op_code", 32'(op_code), 32'(wr));
    check("cmd_sector_address", 32'(sector_address), 32'(a));
    n = 0;
    while (exec_cnt == e0 && n < 20) begin tick(); n++; end
    check("cmd_execute_seen", 32'(exec_cnt - e0), 32'd1);
  endtask

  // Card-controller model: paces bytes, captures or supplies data, closes the sector.
  task automatic run_xfer(input logic wr, input int nbytes, input bit rnd, input bit finish,
                          input logic exp_err, input int e0, input string tag);
    int bad = 0, first_i = 0, n = 0;
    int d0 = done_cnt;
    logic [7:0] first_got = '0, first_exp = '0, data;
    busy = 1'b1;
    tick(2);
    for (int i = 0; i < nbytes; i++) begin
      tick(int'($urandom_range(1, 3)));
      if (wr && i < 512 && outgoing_byte !== model[i]) begin
        if (bad == 0) begin first_i = i; first_got = outgoing_byte; first_exp = model[i]; end
        bad++;
      end
      data = rnd ? 8'($urandom) : 8'(i);
      incoming_byte = data;
      finished_byte = 1'b1;
      tick();
      finished_byte = 1'b0;
      if (!wr && i < 512) model[i] = data;
    end
    if (wr) begin
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL %s_outgoing: %0d wrong bytes, first at %0d got 0x%0h expected 0x%0h",
                 tag, bad, first_i, first_got, first_exp);
      end
    end
    if (finish) begin
      tick();
      finished_sector = 1'b1;
      tick();
      finished_sector = 1'b0;
      tick(2);
      busy = 1'b0;
      while (done_cnt == d0 && n < 50) begin tick(); n++; end
      tick(3);
      check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      check({tag, "_one_execute"}, 32'(exec_cnt - e0), 32'd1);
    end
  endtask

  initial begin
    int e0, lat;
    logic wr;
    logic [25:0] a;
    logic [8:0] ra;

    vecs[0] = '{1'b1, 9'h000, 8'h11, 8'h00};
    vecs[1] = '{1'b1, 9'h1FF, 8'h22, 8'h00};
    vecs[2] = '{1'b1, 9'h0AA, 8'h33, 8'h00};
    vecs[3] = '{1'b0, 9'h000, 8'h00, 8'h11};
    vecs[4] = '{1'b0, 9'h1FF, 8'h00, 8'h22};
    vecs[5] = '{1'b0, 9'h0AA, 8'h00, 8'h33};
    vecs[6] = '{1'b1, 9'h0AA, 8'h5C, 8'h00};
    vecs[7] = '{1'b0, 9'h0AA, 8'h00, 8'h5C};

    // Reset held for 50 cycles
    tick(50);
    check("rst_execute", 32'(execute), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_op_code", 32'(op_code), 0);
    check("rst_sector_address", 32'(sector_address), 0);
    check("rst_outgoing_byte", 32'(outgoing_byte), 0);
    check("rst_host_rdata", 32'(host_rdata), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    btn = 1'b1;
    tick();
    check("rst_cmd_ready_after", 32'(cmd_ready), 1);

    for (int i = 0; i < 512; i++) model[i] = '0;
    foreach (vecs[i]) begin
      host_addr = vecs[i].addr; host_wdata = vecs[i].wdata; host_we = vecs[i].we;
      tick();
      host_we = 1'b0;
      if (vecs[i].we) model[vecs[i].addr] = vecs[i].wdata;
      else check($sformatf("host_vec%0d", i), 32'(host_rdata), 32'(vecs[i].exp_rdata));
    end

    // Timeout: the card never goes busy
    check("to_cmd_ready", 32'(to_cmd_ready), 1);
    to_cmd_valid = 1'b1;
    tick();
    to_cmd_valid = 1'b0;
    for (int n = 0; n < 1100 && to_done_cyc < 0; n++) tick();
    tick(3);
    lat = to_done_cyc - to_exec_cyc;
    tests++;
    if (to_exec_cyc < 0 || to_done_cyc < 0 || lat < 998 || lat > 1002) begin
      fails++;
      $display("FAIL to_latency: got %0d cycles (exec %0d done %0d), expected 1000+/-2",
               lat, to_exec_cyc, to_done_cyc);
    end
    check("to_error", 32'(to_error), 1);
    check("to_one_execute", 32'(to_exec_cnt), 1);

    // Read sector 0x123, bytes i&0xFF
    issue_cmd(1'b0, 26'h0000123, e0);
    run_xfer(1'b0, 512, 1'b0, 1'b1, 1'b0, e0, "read");
    host_addr = 9'h1FF;
    tick();
    check("read_last_byte", 32'(host_rdata), 32'h0000_00FF);

    // Write: host fills 0xA5^i
    for (int i = 0; i < 512; i++) host_write(9'(i), 8'(i) ^ 8'hA5);
    issue_cmd(1'b1, 26'h0000456, e0);
    run_xfer(1'b1, 512, 1'b0, 1'b1, 1'b0, e0, "write");

    // Short sector, with host_we and cmd_valid ignored while busy
    issue_cmd(1'b0, 26'h0000777, e0);
    host_addr = 9'h155; host_wdata = ~model[9'h155]; host_we = 1'b1; cmd_valid = 1'b1;
    tick(3);
    host_we = 1'b0; cmd_valid = 1'b0;
    run_xfer(1'b0, 100, 1'b1, 1'b1, 1'b1, e0, "short");
    tick(10);
    check("short_no_queued_cmd", 32'(exec_cnt - e0), 1);
    check("short_error_sticky", 32'(error), 1);
    host_read_check("host_we_ignored", 9'h155);
    host_read_check("short_byte99", 9'h063);

    // Overrun: 513 bytes, the last is dropped
    issue_cmd(1'b0, 26'h3FFFFFF, e0);
    run_xfer(1'b0, 513, 1'b1, 1'b1, 1'b1, e0, "overrun");
    host_read_check("overrun_byte0", 9'h000);

    // Random transfers against the buffer model
    for (int k = 0; k < 6; k++) begin
      wr = 1'($urandom);
      a = 26'($urandom);
      if (wr) for (int j = 0; j < 16; j++) host_write(9'($urandom), 8'($urandom));
      issue_cmd(wr, a, e0);
      run_xfer(wr, 512, 1'b1, 1'b1, 1'b0, e0, $sformatf("rand%0d", k));
      for (int j = 0; j < 4; j++) begin
        ra = 9'($urandom);
        host_read_check($sformatf("rand%0d_rd%0d", k, j), ra);
      end
    end

    // Reset in the middle of a read at byte 200
    issue_cmd(1'b0, 26'h0000ABC, e0);
    run_xfer(1'b0, 200, 1'b1, 1'b0, 1'b0, e0, "mid");
    btn = 1'b0;
    tick();
    check("mid_rst_execute", 32'(execute), 0);
    check("mid_rst_op_code", 32'(op_code), 0);
    check("mid_rst_sector_address", 32'(sector_address), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_host_rdata", 32'(host_rdata), 0);
    btn = 1'b1;
    busy = 1'b0;
    e0 = exec_cnt;
    tick(20);
    check("mid_no_execute", 32'(exec_cnt - e0), 0);
    check("mid_cmd_ready", 32'(cmd_ready), 1);
    host_read_check("mid_ram_kept", 9'd199);
    issue_cmd(1'b0, 26'h0000DEF, e0);
    run_xfer(1'b0, 512, 1'b1, 1'b1, 1'b0, e0, "after_rst");
    host_read_check("after_rst_byte", 9'h1FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
